// File: rtl/spi_sdo_capture.sv
// SPI mode-0 read controller: selects a target, clocks WIDTH bits in MSB-first
// from spi_sdo and presents the word on a valid/ready handshake.
module spi_sdo_capture #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 2,
  parameter int SEL_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] sel,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  input  logic             spi_sdo,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]       state_reg;
  logic [DW-1:0]    div_reg;
  logic [BW-1:0]    bit_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH:0]   shift_ext;
  logic [SEL_W-1:0] sel_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             sclk_reg;
  logic             cs_n_reg;
  logic             busy_reg;
  logic             rx_valid_reg;
  logic             overrun_reg;
  logic             phase_done;

  // Shift left with the new bit entering at the LSB; works for WIDTH == 1 too.
  assign shift_ext  = {shift_reg, spi_sdo};
  assign shift_next = shift_ext[WIDTH-1:0];
  assign phase_done = (div_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      div_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      sel_reg      <= '0;
      rx_data_reg  <= '0;
      sclk_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sel_reg   <= sel_in;
            cs_n_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            div_reg   <= DIV_LOAD;
            bit_reg   <= BIT_LOAD;
            shift_reg <= '0;
            state_reg <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_done) begin
            sclk_reg  <= 1'b1;
            shift_reg <= shift_next;
            div_reg   <= DIV_LOAD;
            state_reg <= S_HIGH;
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_done) begin
            sclk_reg  <= 1'b0;
            div_reg   <= DIV_LOAD;
            state_reg <= S_LOW;
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        S_LOW: begin
          if (phase_done) begin
            div_reg <= DIV_LOAD;
            if (bit_reg == '0) begin
              state_reg <= S_HOLD;
            end else begin
              bit_reg   <= bit_reg - 1'b1;
              sclk_reg  <= 1'b1;
              shift_reg <= shift_next;
              state_reg <= S_HIGH;
            end
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        S_HOLD: begin
          if (phase_done) begin
            // A word landing on an unconsumed one is an overrun unless it is
            // being consumed on this very edge.
            cs_n_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            rx_data_reg  <= shift_reg;
            rx_valid_reg <= 1'b1;
            overrun_reg  <= overrun_reg | (rx_valid_reg & ~rx_ready);
            state_reg    <= S_IDLE;
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          cs_n_reg  <= 1'b1;
          sclk_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sel      = sel_reg;
  assign spi_cs_n = cs_n_reg;
  assign spi_sclk = sclk_reg;
  assign busy     = busy_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_spi_sdo_capture.sv
// Randomised bench for spi_sdo_capture: a behavioural SPI target shifts a word
// out on falling sclk, and each transfer is scored against that word.
module tb_spi_sdo_capture;

  localparam int W  = 16;
  localparam int CD = 2;
  localparam int BW8 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  sel_in;
  logic [3:0]  sel;
  logic        spi_cs_n, spi_sclk, spi_sdo, busy, rx_valid, rx_ready, overrun;
  logic [W-1:0] rx_data;

  logic        b_start, b_cs_n, b_sclk, b_sdo, b_busy, b_valid, b_overrun;
  logic [3:0]  b_sel;
  logic [BW8-1:0] b_data;

  always #5 clk = ~clk;

  spi_sdo_capture #(.WIDTH(W), .CLK_DIV(CD), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_in(sel_in), .sel(sel),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_sdo(spi_sdo), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun)
  );

  spi_sdo_capture #(.WIDTH(BW8), .CLK_DIV(1), .SEL_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(b_start), .sel_in(4'd0), .sel(b_sel),
    .spi_cs_n(b_cs_n), .spi_sclk(b_sclk), .spi_sdo(b_sdo), .busy(b_busy),
    .rx_data(b_data), .rx_valid(b_valid), .rx_ready(1'b1), .overrun(b_overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural target: one addressed target, mux yields 0 for any other sel.
  logic [3:0]     tgt_sel;
  logic [W-1:0]   tgt_word;
  int             idx = -1;
  int             rises = 0;
  int             busy_falls = 0;
  always @(negedge spi_cs_n) idx = W - 1;
  always @(negedge spi_sclk) if (!spi_cs_n) idx--;
  always @(posedge spi_sclk) rises++;
  always @(negedge busy) busy_falls++;
  assign spi_sdo = (idx >= 0 && sel == tgt_sel) ? tgt_word[idx] : 1'b0;

  logic [BW8-1:0] b_word;
  int             b_idx = -1;
  always @(negedge b_cs_n) b_idx = BW8 - 1;
  always @(negedge b_sclk) if (!b_cs_n) b_idx--;
  assign b_sdo = (b_idx >= 0) ? b_word[b_idx] : 1'b0;

  // One transfer; returns edges from acceptance to completion and cs_n-low cycles.
  task automatic do_xfer(input logic [3:0] s, input bit rdy, input bit pulse,
                         output int lat, output int cs_low);
    @(negedge clk);
    start = 1'b1; sel_in = s; rx_ready = rdy; rises = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 0; cs_low = 0;
    while (busy && lat < 400) begin
      if (!spi_cs_n) cs_low++;
      start = (pulse && lat == 10);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  int lat, cs_low, n_falls;
  logic [W-1:0] exp_word;

  initial begin
    rst = 1'b1; start = 1'b0; sel_in = '0; rx_ready = 1'b0; b_start = 1'b0;
    tgt_sel = 4'd0; tgt_word = '1; b_word = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1); check("rst_sclk", spi_sclk, 0);
    check("rst_busy", busy, 0);     check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);  check("rst_sel", sel, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;

    // All-ones target at sel 0, latency and framing.
    do_xfer(4'd0, 1'b1, 1'b0, lat, cs_low);
    check("t1_data", rx_data, 16'hFFFF); check("t1_valid", rx_valid, 1);
    check("t1_lat", lat, CD * (2 * W + 2)); check("t1_cslow", cs_low, CD * (2 * W + 2));
    check("t1_rises", rises, W);

    // Sweep non-addressed targets.
    for (int s = 1; s < 16; s++) begin
      do_xfer(4'(s), 1'b1, 1'b0, lat, cs_low);
      check($sformatf("t2_sel%0d", s), sel, s);
      check($sformatf("t2_data%0d", s), rx_data, 0);
    end
    check("t2_ovr", overrun, 0);

    tgt_word = 16'hA5C3;
    do_xfer(4'd0, 1'b1, 1'b0, lat, cs_low);
    check("t3_data", rx_data, 16'hA5C3);

    // 8-bit, CLK_DIV=1 instance.
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0; lat = 0;
    while (b_busy && lat < 100) begin @(negedge clk); lat++; end
    check("t3b_data", b_data, 8'h5A); check("t3b_lat", lat, 2 * BW8 + 2);

    // Random targets, words and selects.
    for (int i = 0; i < 10; i++) begin
      tgt_sel  = 4'($urandom_range(0, 15));
      tgt_word = 16'($urandom);
      sel_in   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : tgt_sel;
      exp_word = (sel_in == tgt_sel) ? tgt_word : '0;
      do_xfer(sel_in, 1'b1, 1'b0, lat, cs_low);
      check($sformatf("rnd%0d_data", i), rx_data, exp_word);
      check($sformatf("rnd%0d_rises", i), rises, W);
    end

    // Start pulsed mid-transfer must be ignored.
    tgt_sel = 4'd3; tgt_word = 16'h7E81;
    @(negedge clk); busy_falls = 0;
    do_xfer(4'd3, 1'b1, 1'b1, lat, cs_low);
    check("t5_data", rx_data, 16'h7E81); check("t5_lat", lat, CD * (2 * W + 2));
    repeat (80) @(negedge clk);
    n_falls = busy_falls;
    check("t5_falls", n_falls, 1); check("t5_idle_cs", spi_cs_n, 1);

    // Overrun with the consumer stalled.
    tgt_word = 16'h1234;
    do_xfer(4'd3, 1'b0, 1'b0, lat, cs_low);
    check("t4_first", rx_data, 16'h1234); check("t4_ovr0", overrun, 0);
    tgt_word = 16'hBEEF;
    do_xfer(4'd3, 1'b0, 1'b0, lat, cs_low);
    check("t4_data", rx_data, 16'hBEEF); check("t4_ovr1", overrun, 1);
    check("t4_valid", rx_valid, 1);
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    check("t4_consumed", rx_valid, 0); check("t4_ovr_sticky", overrun, 1);

    // Reset in the middle of a transfer.
    @(negedge clk); start = 1'b1; sel_in = 4'd3;
    @(negedge clk); start = 1'b0;
    repeat (29) @(negedge clk);
    check("t6_mid_cs", spi_cs_n, 0);
    rst = 1'b1; #1;
    check("t6_cs_n", spi_cs_n, 1); check("t6_sclk", spi_sclk, 0);
    check("t6_valid", rx_valid, 0); check("t6_busy", busy, 0);
    check("t6_ovr", overrun, 0);
    @(negedge clk); rst = 1'b0;
    tgt_word = 16'hC0DE;
    do_xfer(4'd3, 1'b1, 1'b0, lat, cs_low);
    check("t6_data", rx_data, 16'hC0DE); check("t6_lat", lat, CD * (2 * W + 2));
    check("t6_sel", sel, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
